// File: rtl/led_mode_ctrl.sv
// Mode-button front end: synchronizes and debounces the button, steps the mode, emits per-mode tick/restart, muxes LEDs.
// Button-to-mode latency DEB_CYCLES+3 cycles; led lags the selected input by 1 cycle; no backpressure.
module led_mode_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic [7:0] mode0_in,
    input  logic [7:0] mode1_in,
    input  logic [7:0] mode2_in,
    input  logic [7:0] mode3_in,
    output logic [3:0] en,
    output logic [3:0] mode_rst,
    output logic [1:0] mode,
    output logic [7:0] led
);
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_deb;
    logic          r_deb_prev;
    logic [TW-1:0] r_tcnt;
    logic [1:0]    r_mode;
    logic [3:0]    r_en;
    logic [3:0]    r_mode_rst;
    logic [7:0]    r_led;

    logic          w_step;
    logic [1:0]    w_mode_inc;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_deb_nxt;
    logic [TW-1:0] w_tcnt_nxt;
    logic [1:0]    w_mode_nxt;
    logic [3:0]    w_en_nxt;
    logic [3:0]    w_rst_nxt;
    logic [7:0]    w_led_nxt;

    assign w_step     = r_deb & ~r_deb_prev;
    assign w_mode_inc = r_mode + 2'd1;

    always_comb begin
        w_cnt_nxt = '0;
        w_deb_nxt = r_deb;
        if (r_sync2 != r_deb) begin
            if (r_cnt == C_LAST) begin
                w_deb_nxt = r_sync2;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // A press edge takes priority over the terminal count so en and mode_rst never coincide.
    always_comb begin
        w_tcnt_nxt = r_tcnt + 1'b1;
        w_mode_nxt = r_mode;
        w_en_nxt   = 4'b0000;
        w_rst_nxt  = 4'b0000;
        if (w_step) begin
            w_tcnt_nxt = '0;
            w_mode_nxt = w_mode_inc;
            w_rst_nxt  = 4'b0001 << w_mode_inc;
        end else if (r_tcnt == T_LAST) begin
            w_tcnt_nxt = '0;
            w_en_nxt   = 4'b0001 << r_mode;
        end
    end

    always_comb begin
        w_led_nxt = mode0_in;
        case (r_mode)
            2'd0: w_led_nxt = mode0_in;
            2'd1: w_led_nxt = mode1_in;
            2'd2: w_led_nxt = mode2_in;
            2'd3: w_led_nxt = mode3_in;
            default: w_led_nxt = mode0_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_cnt      <= '0;
            r_deb      <= 1'b0;
            r_deb_prev <= 1'b0;
            r_tcnt     <= '0;
            r_mode     <= 2'd0;
            r_en       <= 4'b0000;
            r_mode_rst <= 4'b0000;
            r_led      <= 8'h00;
        end else begin
            r_sync1    <= btn_mode;
            r_sync2    <= r_sync1;
            r_cnt      <= w_cnt_nxt;
            r_deb      <= w_deb_nxt;
            r_deb_prev <= r_deb;
            r_tcnt     <= w_tcnt_nxt;
            r_mode     <= w_mode_nxt;
            r_en       <= w_en_nxt;
            r_mode_rst <= w_rst_nxt;
            r_led      <= w_led_nxt;
        end
    end

    assign en       = r_en;
    assign mode_rst = r_mode_rst;
    assign mode     = r_mode;
    assign led      = r_led;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Randomized bench for led_mode_ctrl against a sample-window / phase-count reference model.
module tb_led_mode_ctrl;
    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic [7:0] mode_in [4];
    logic [3:0] en;
    logic [3:0] mode_rst;
    logic [1:0] mode;
    logic [7:0] led;

    led_mode_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode),
        .mode0_in(mode_in[0]), .mode1_in(mode_in[1]),
        .mode2_in(mode_in[2]), .mode3_in(mode_in[3]),
        .en(en), .mode_rst(mode_rst), .mode(mode), .led(led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: debounced level flips once the last DB synchronized samples all disagree with it;
    // ticks fire when the number of cycles since the last restart is one short of a multiple of TD.
    bit   hist[$];
    bit   m_s1, m_s2, m_deb, m_dprev;
    int   m_mode, m_k;
    logic [3:0] m_en, m_rst;
    logic [7:0] m_led;

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < DB; i++) hist.push_back(1'b0);
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_dprev = 0;
        m_mode = 0; m_k = 0; m_en = 0; m_rst = 0; m_led = 0;
    endtask

    task automatic model_edge();
        bit step, all_diff;
        if (reset) begin
            model_clear();
            return;
        end
        step = m_deb && !m_dprev;
        hist.push_back(m_s2);
        void'(hist.pop_front());
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;
        m_dprev = m_deb;
        if (all_diff) m_deb = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_mode;
        m_led = mode_in[m_mode];
        if (step) begin
            m_mode = (m_mode + 1) % 4;
            m_rst = 4'(1 << m_mode);
            m_en = 0;
            m_k = 0;
        end else begin
            m_rst = 0;
            m_en = ((m_k % TD) == TD - 1) ? 4'(1 << m_mode) : 4'b0;
            m_k++;
        end
    endtask

    task automatic cyc(input bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) begin
            chk("mode", 32'(mode), 32'(m_mode));
            chk("en", 32'(en), 32'(m_en));
            chk("mode_rst", 32'(mode_rst), 32'(m_rst));
            chk("led", 32'(led), 32'(m_led));
        end
    endtask

    initial begin
        int n, hold;
        bit found;
        model_clear();
        reset = 1; btn_mode = 0;
        mode_in[0] = 8'hFF; mode_in[1] = 8'h0F; mode_in[2] = 8'hAA; mode_in[3] = 8'h55;
        cyc(0);
        cyc(1);
        chk("reset_mode", 32'(mode), 0);
        chk("reset_led", 32'(led), 0);
        chk("reset_en", 32'(en), 0);
        chk("reset_rst", 32'(mode_rst), 0);
        reset = 0;
        for (int i = 0; i < 12; i++) cyc(1);

        // Press latency: button high before edge 1, restart expected at edge DB+3.
        btn_mode = 1;
        n = 0; found = 0;
        while (!found && n < 50) begin
            cyc(1); n++;
            if (mode_rst != 0) found = 1;
        end
        chk("press_latency", 32'(n), DB + 3);
        chk("press_rst", 32'(mode_rst), 32'h2);
        chk("press_mode", 32'(mode), 1);
        n = 0; found = 0;
        while (!found && n < 50) begin
            cyc(1); n++;
            if (en != 0) found = 1;
        end
        chk("first_en_delay", 32'(n), TD);
        chk("first_en_val", 32'(en), 32'h2);
        for (int i = 0; i < 20; i++) cyc(1);
        chk("held_no_step", 32'(mode), 1);

        btn_mode = 0;
        for (int i = 0; i < 10; i++) cyc(1);
        // Short glitches must not step the mode.
        for (int g = 0; g < 3; g++) begin
            btn_mode = 1; cyc(1); cyc(1);
            btn_mode = 0; cyc(1); cyc(1);
        end
        for (int i = 0; i < 8; i++) cyc(1);
        chk("glitch_mode", 32'(mode), 1);

        // Four clean presses walk the mode around and back.
        for (int p = 0; p < 4; p++) begin
            btn_mode = 1;
            for (int i = 0; i < 9; i++) cyc(1);
            btn_mode = 0;
            for (int i = 0; i < 9; i++) cyc(1);
        end
        chk("wrap_mode", 32'(mode), 1);

        // Random mix of holds, glitches, input changes and occasional reset.
        for (int s = 0; s < 600; s++) begin
            btn_mode = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 3) == 0) mode_in[$urandom_range(0, 3)] = 8'($urandom);
            if ($urandom_range(0, 59) == 0) reset = 1;
            for (int i = 0; i < hold; i++) begin
                cyc(1);
                reset = 0;
            end
        end

        // Reset while in mode 2.
        reset = 0; btn_mode = 0;
        for (int i = 0; i < 10; i++) cyc(1);
        n = 0;
        while (mode != 2 && n < 20) begin
            btn_mode = 1;
            for (int i = 0; i < 9; i++) cyc(1);
            btn_mode = 0;
            for (int i = 0; i < 9; i++) cyc(1);
            n++;
        end
        chk("reach_mode2", 32'(mode), 2);
        reset = 1;
        cyc(1);
        chk("midreset_mode", 32'(mode), 0);
        chk("midreset_led", 32'(led), 0);
        reset = 0;
        for (int i = 0; i < 10; i++) cyc(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Front-end controller for the four-mode LED board. It debounces the mode push-button and steps a 2-bit mode register through modes 0→1→2→3→0. It generates the periodic one-cycle `en` tick for the active mode block only, and pulses a per-mode restart. It also muxes the four mode blocks' 8-bit outputs onto the physical LEDs. It sits upstream of the mode blocks (mode 0 = the toggle/blink block) and downstream of the raw board button.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per animation tick; must be ≥2.
- `DEB_CYCLES`, default 1_000_000: consecutive stable synchronized samples needed to accept a button level change; must be ≥1.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `btn_mode` input, 1 bit: raw, asynchronous, active-high mode button.
- `mode0_in` … `mode3_in` input, 8 bits each: LED patterns from mode blocks 0–3.
- `en` output, 4 bits: one-hot tick; bit i pulses only while mode == i.
- `mode_rst` output, 4 bits: one-cycle restart pulse to the newly entered mode block.
- `mode` output, 2 bits: current mode.
- `led` output, 8 bits: registered copy of the selected mode input.

## Operation
- Reset values: `mode`=0, `en`=0, `mode_rst`=0, `led`=0. Internal state clears to 0: sync flops, debounce counter, debounced state, previous debounced state, tick counter.
- Synchronizer: 2-flop chain on `btn_mode` → `sync`.
- Debounce, with `deb` as the debounced state:
  - If `sync`==`deb`: `cnt`←0.
  - Else if `cnt`==DEB_CYCLES-1: `deb`←`sync` and `cnt`←0.
  - Else: `cnt`←`cnt`+1.
  - Counter width is $clog2(DEB_CYCLES)+1.
- Step: `step` = `deb` & ~`deb_prev` (combinational). `deb_prev`←`deb` every cycle. Release edges do nothing.
- Mode register: on `step`, `mode`←`mode`+1, wrapping 3→0.
- Tick counter `tcnt` counts 0..TICK_DIV-1.
- Priority per cycle:
  1. `reset`.
  2. `step`: `tcnt`←0, `en`←0, `mode_rst`←onehot(`mode`+1).
  3. `tcnt`==TICK_DIV-1: `tcnt`←0, `en`←onehot(`mode`), `mode_rst`←0.
  4. Otherwise: `tcnt`←`tcnt`+1, `en`←0, `mode_rst`←0.
- `en` is never asserted for a non-active mode. `en` and `mode_rst` are never asserted in the same cycle.
- `led`←mux(`mode`) of `mode0_in`..`mode3_in` every cycle; it is never gated by `en`.

## Timing
- Button to mode:
  - `btn_mode` first sampled high at edge 1 → `sync` high after edge 2.
  - `deb` rises at edge DEB_CYCLES+2.
  - `mode` and `mode_rst` update at edge DEB_CYCLES+3.
- Glitches shorter than DEB_CYCLES synchronized cycles are ignored. Any mismatch-free cycle clears `cnt`.
- Holding the button advances exactly one mode. The next advance requires a release that is itself debounced (DEB_CYCLES cycles low), followed by a new debounced press.
- Tick period: `en` is high exactly 1 cycle, every TICK_DIV cycles. After a mode change, the first `en` of the new mode arrives TICK_DIV cycles after the `mode_rst` cycle.
- If `step` and the terminal count coincide, `step` wins: no `en` that cycle, and the counter restarts.
- `led` lags the selected input by 1 cycle. After a mode change it shows the new mode's input from the edge after `mode` updates.
- `reset` mid-operation: all outputs return to reset values at the next edge. A button held through reset is re-debounced from `deb`=0 and produces one step after release of reset.

## Test plan
- Reset, with TICK_DIV=4 and DEB_CYCLES=3. Hold `reset` 2 cycles, then release → `mode`=0, `led`=0, `en`=0000, `mode_rst`=0000. After release, `en`=0001 for 1 cycle every 4 cycles; `en`[3:1] stay 0.
- Debounced press. Raise `btn_mode` at edge 1 and hold → `mode`=1 and `mode_rst`=0010 (1 cycle) at edge 6. The next `en`=0010 arrives 4 cycles later. No further steps while held.
- Glitch rejection. Pulse `btn_mode` high for 2 cycles, repeated 3 times with 2-cycle gaps → `mode` stays 0, `mode_rst` stays 0000.
- Wrap-around. Perform 4 clean press/release cycles → `mode` goes 1,2,3,0. `mode_rst` values are 0010, 0100, 1000, 0001.
- Mux and latency. Drive `mode0_in`=8'hFF, `mode1_in`=8'h0F, `mode2_in`=8'hAA, `mode3_in`=8'h55 → `led` equals the value for the current `mode` one cycle after each mode change. Changing the selected input shows up on `led` one cycle later.
- Collision and reset mid-operation:
  - Align `step` with `tcnt`==3 → `en`=0000 and `mode_rst` asserted in that cycle; `tcnt` restarts.
  - Assert `reset` while in mode 2 → `mode`=0 and `led`=0 at the next edge.
